// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit execute-stage ALU: op encodings and datapath width.
package alu_pkg;

    // Default datapath width. All behaviour is defined for 8 bits.
    localparam int ALU_WIDTH = 8;

    // Shift amount is the full second operand.
    localparam int ALU_AMT_WIDTH = 8;

    // Operation select encoding, shared with the decoder/control unit.
    typedef logic [1:0] alu_op_t;

    localparam alu_op_t ALU_ADD = 2'b00;
    localparam alu_op_t ALU_SUB = 2'b01;
    localparam alu_op_t ALU_SLL = 2'b10;
    localparam alu_op_t ALU_AND = 2'b11;

    // High when every bit of the value is clear.
    function automatic logic is_zero(input logic [ALU_WIDTH-1:0] value);
        return (value == '0);
    endfunction

endpackage : alu_pkg

// File: rtl/alu_shifter.sv
// Combinational logical left shifter. The whole amount operand is honoured:
// any amount at or beyond the data width shifts every bit out and gives 0.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH     = ALU_WIDTH,
    parameter int AMT_WIDTH = ALU_AMT_WIDTH
) (
    input  logic [WIDTH-1:0]     data,
    input  logic [AMT_WIDTH-1:0] amount,
    output logic [WIDTH-1:0]     shifted
);

    // Number of amount bits that select a real in-range shift.
    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] staged;
    logic             out_of_range;

    // Log-depth barrel shift on the low amount bits, one stage per bit.
    always_comb begin
        staged = data;
        for (int i = 0; i < SHW; i++) begin
            if (amount[i]) begin
                staged = staged << (32'd1 << i);
            end
        end
    end

    // Any set bit above the in-range field means amount >= WIDTH.
    assign out_of_range = |amount[AMT_WIDTH-1:SHW];

    // Saturate to zero for oversized shifts, otherwise pass the staged value.
    always_comb begin
        shifted = staged;
        if (out_of_range) begin
            shifted = '0;
        end
    end

endmodule : alu_shifter

// File: rtl/alu.sv
// Execute-stage ALU: ADD, SUB, SLL, AND on unsigned operands with a registered
// result plus zero and carry flags, one cycle of latency.
// There is no handshake: a new operation is accepted on every clock edge and
// its result is visible after that edge until the next one.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] rs_data1,
    input  logic [WIDTH-1:0] rs_data2,
    input  logic [1:0]       immediate,
    input  alu_op_t          alu_op,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry
);

    // immediate is reserved for future address ops and deliberately unused.
    logic unused_immediate;
    assign unused_immediate = ^immediate;

    // Add/sub path: one adder, SUB feeds ~rs_data2 with carry-in 1.
    logic             is_sub;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum_ext;
    logic             borrow;

    assign is_sub  = (alu_op == ALU_SUB);
    assign addend  = is_sub ? ~rs_data2 : rs_data2;
    assign sum_ext = {1'b0, rs_data1} + {1'b0, addend} + {{WIDTH{1'b0}}, is_sub};
    // With two's-complement subtraction the carry-out is high when no borrow.
    assign borrow  = ~sum_ext[WIDTH];

    // Shift path.
    logic [WIDTH-1:0] shift_value;

    alu_shifter #(
        .WIDTH     (WIDTH),
        .AMT_WIDTH (WIDTH)
    ) u_shifter (
        .data    (rs_data1),
        .amount  (rs_data2),
        .shifted (shift_value)
    );

    // AND path.
    logic [WIDTH-1:0] and_value;
    assign and_value = rs_data1 & rs_data2;

    logic [WIDTH-1:0] result_next;
    logic             carry_next;
    logic             zero_next;

    // Op mux: select the next result and carry; every encoding is defined.
    always_comb begin
        result_next = sum_ext[WIDTH-1:0];
        carry_next  = 1'b0;
        case (alu_op)
            ALU_ADD: begin
                result_next = sum_ext[WIDTH-1:0];
                carry_next  = sum_ext[WIDTH];
            end
            ALU_SUB: begin
                result_next = sum_ext[WIDTH-1:0];
                carry_next  = borrow;
            end
            ALU_SLL: begin
                result_next = shift_value;
                carry_next  = 1'b0;
            end
            ALU_AND: begin
                result_next = and_value;
                carry_next  = 1'b0;
            end
            default: begin
                result_next = sum_ext[WIDTH-1:0];
                carry_next  = 1'b0;
            end
        endcase
    end

    // Zero flag comes from the very value about to be loaded into result.
    assign zero_next = (result_next == '0);

    // Output registers; reset forces the empty-result state 0 / zero / no carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            zero   <= 1'b1;
            carry  <= 1'b0;
        end else begin
            result <= result_next;
            zero   <= zero_next;
            carry  <= carry_next;
        end
    end

endmodule : alu

// File: tb/tb_alu.sv
// Directed bench for alu: each step drives one operation, waits one edge,
// and checks result/zero/carry against hand-computed values.
module tb_alu;
    import alu_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] rs_data1;
    logic [7:0] rs_data2;
    logic [1:0] immediate;
    alu_op_t    alu_op;
    logic [7:0] result;
    logic       zero;
    logic       carry;

    int checks_total;
    int checks_passed;

    alu #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .rs_data1  (rs_data1),
        .rs_data2  (rs_data2),
        .immediate (immediate),
        .alu_op    (alu_op),
        .result    (result),
        .zero      (zero),
        .carry     (carry)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare all three outputs against expectations.
    task automatic check(input string tag, input logic [7:0] exp_result,
                         input logic exp_zero, input logic exp_carry);
        checks_total++;
        assert (result === exp_result) begin
            checks_passed++;
        end else begin
            $error("FAIL %s result: got %0d expected %0d", tag, result, exp_result);
        end
        checks_total++;
        assert (zero === exp_zero) begin
            checks_passed++;
        end else begin
            $error("FAIL %s zero: got %0b expected %0b", tag, zero, exp_zero);
        end
        checks_total++;
        assert (carry === exp_carry) begin
            checks_passed++;
        end else begin
            $error("FAIL %s carry: got %0b expected %0b", tag, carry, exp_carry);
        end
    endtask

    // Drive one op, let one edge load it, then sample just after the edge.
    task automatic step(input logic r, input alu_op_t op, input logic [7:0] a,
                        input logic [7:0] b, input logic [1:0] imm);
        rst       = r;
        alu_op    = op;
        rs_data1  = a;
        rs_data2  = b;
        immediate = imm;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        rst       = 1'b1;
        alu_op    = ALU_ADD;
        rs_data1  = 8'd0;
        rs_data2  = 8'd0;
        immediate = 2'b00;

        // Reset held for two edges with ADD 10,5 applied.
        step(1'b1, ALU_ADD, 8'd10, 8'd5, 2'b00);
        check("reset_edge1", 8'd0, 1'b1, 1'b0);
        step(1'b1, ALU_ADD, 8'd10, 8'd5, 2'b00);
        check("reset_edge2", 8'd0, 1'b1, 1'b0);
        step(1'b0, ALU_ADD, 8'd10, 8'd5, 2'b00);
        check("reset_release_add", 8'd15, 1'b0, 1'b0);

        // ADD
        step(1'b0, ALU_ADD, 8'd200, 8'd100, 2'b00);
        check("add_200_100", 8'd44, 1'b0, 1'b1);
        step(1'b0, ALU_ADD, 8'd128, 8'd128, 2'b00);
        check("add_128_128", 8'd0, 1'b1, 1'b1);

        // SUB
        step(1'b0, ALU_SUB, 8'd20, 8'd8, 2'b00);
        check("sub_20_8", 8'd12, 1'b0, 1'b0);
        step(1'b0, ALU_SUB, 8'd8, 8'd20, 2'b00);
        check("sub_8_20", 8'd244, 1'b0, 1'b1);
        step(1'b0, ALU_SUB, 8'd7, 8'd7, 2'b00);
        check("sub_7_7", 8'd0, 1'b1, 1'b0);

        // SLL
        step(1'b0, ALU_SLL, 8'd8, 8'd2, 2'b00);
        check("sll_8_2", 8'd32, 1'b0, 1'b0);
        step(1'b0, ALU_SLL, 8'd1, 8'd7, 2'b00);
        check("sll_1_7", 8'd128, 1'b0, 1'b0);
        step(1'b0, ALU_SLL, 8'd255, 8'd7, 2'b00);
        check("sll_255_7", 8'd128, 1'b0, 1'b0);
        step(1'b0, ALU_SLL, 8'd3, 8'd0, 2'b00);
        check("sll_3_0", 8'd3, 1'b0, 1'b0);
        step(1'b0, ALU_SLL, 8'd255, 8'd8, 2'b00);
        check("sll_255_8", 8'd0, 1'b1, 1'b0);
        step(1'b0, ALU_SLL, 8'd3, 8'd200, 2'b00);
        check("sll_3_200", 8'd0, 1'b1, 1'b0);

        // AND
        step(1'b0, ALU_AND, 8'd15, 8'd10, 2'b00);
        check("and_15_10", 8'd10, 1'b0, 1'b0);
        step(1'b0, ALU_AND, 8'hF0, 8'h0F, 2'b00);
        check("and_f0_0f", 8'd0, 1'b1, 1'b0);

        // immediate sweep: outputs must not depend on it
        for (int i = 0; i < 4; i++) begin
            step(1'b0, ALU_ADD, 8'd200, 8'd100, 2'(i));
            check($sformatf("imm%0d_add", i), 8'd44, 1'b0, 1'b1);
            step(1'b0, ALU_SUB, 8'd8, 8'd20, 2'(i));
            check($sformatf("imm%0d_sub", i), 8'd244, 1'b0, 1'b1);
            step(1'b0, ALU_SLL, 8'd8, 8'd2, 2'(i));
            check($sformatf("imm%0d_sll", i), 8'd32, 1'b0, 1'b0);
            step(1'b0, ALU_AND, 8'd15, 8'd10, 2'(i));
            check($sformatf("imm%0d_and", i), 8'd10, 1'b0, 1'b0);
        end
        step(1'b0, ALU_SUB, 8'd20, 8'd8, 2'bxx);
        check("immx_sub", 8'd12, 1'b0, 1'b0);

        // Back-to-back ops with a mid-stream reset.
        step(1'b0, ALU_ADD, 8'd1, 8'd2, 2'b00);
        check("b2b_add", 8'd3, 1'b0, 1'b0);
        step(1'b0, ALU_SUB, 8'd9, 8'd4, 2'b01);
        check("b2b_sub", 8'd5, 1'b0, 1'b0);
        step(1'b0, ALU_SLL, 8'd5, 8'd1, 2'b10);
        check("b2b_sll", 8'd10, 1'b0, 1'b0);
        step(1'b1, ALU_ADD, 8'd200, 8'd100, 2'b00);
        check("b2b_reset", 8'd0, 1'b1, 1'b0);
        step(1'b0, ALU_AND, 8'hAA, 8'hCC, 2'b11);
        check("b2b_and", 8'h88, 1'b0, 1'b0);
        step(1'b0, ALU_ADD, 8'd255, 8'd1, 2'b00);
        check("b2b_add_wrap", 8'd0, 1'b1, 1'b1);
        step(1'b0, ALU_SUB, 8'd0, 8'd1, 2'b00);
        check("b2b_sub_wrap", 8'd255, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule : tb_alu
